// File: rtl/mac_acc_pipe.sv
// Two-stage multiply-accumulate: stage 1 registers the product, stage 2 folds it
// into a running sum with optional saturation, a sticky overflow flag and a product count.
module mac_acc_pipe #(
  parameter int N      = 16,
  parameter int ACC_W  = 40,
  parameter int SIGNED = 0,
  parameter int SAT    = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             clear,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  output logic [ACC_W-1:0] accumulator,
  output logic             acc_valid,
  output logic             overflow,
  output logic [CNT_W-1:0] mac_count
);

  localparam int   PW     = 2 * N;
  localparam logic SGN    = (SIGNED != 0);
  localparam logic SAT_EN = (SAT != 0);

  function automatic logic [ACC_W-1:0] ext_prod(input logic [PW-1:0] p);
    logic signed [PW-1:0] ps;
    ps = p;
    return SGN ? ACC_W'(ps) : ACC_W'(p);
  endfunction

  // Returns {overflow, result}; result is clamped when saturation is enabled.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W:0]   s;
    logic             ovf;
    logic [ACC_W-1:0] r;
    s = {1'b0, a} + {1'b0, b};
    if (SGN) ovf = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    else     ovf = s[ACC_W];
    r = s[ACC_W-1:0];
    if (ovf && SAT_EN) begin
      if (SGN) r = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else     r = '1;
    end
    return {ovf, r};
  endfunction

  // Stage 1: product register
  logic [PW-1:0] prod_p1_d, prod_p1_q;
  logic          vld_p1_d, vld_p1_q;
  logic          clr_p1_d, clr_p1_q;

  always_comb begin
    prod_p1_d = {{N{SGN & A[N-1]}}, A} * {{N{SGN & B[N-1]}}, B};
    vld_p1_d  = in_valid;
    clr_p1_d  = clear;
  end

  always_ff @(posedge clk) begin
    if (reset) vld_p1_q <= 1'b0;
    else       vld_p1_q <= vld_p1_d;
  end

  always_ff @(posedge clk) begin
    prod_p1_q <= prod_p1_d;
    clr_p1_q  <= clr_p1_d;
  end

  // Stage 2: accumulate
  logic [ACC_W-1:0] acc_p2_d, acc_p2_q;
  logic             ovf_p2_d, ovf_p2_q;
  logic             vld_p2_d, vld_p2_q;
  logic [CNT_W-1:0] cnt_p2_d, cnt_p2_q;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   add_res;

  always_comb begin
    acc_p2_d = acc_p2_q;
    ovf_p2_d = ovf_p2_q;
    cnt_p2_d = cnt_p2_q;
    vld_p2_d = vld_p1_q;
    prod_ext = ext_prod(prod_p1_q);
    add_res  = sat_add(acc_p2_q, prod_ext);
    if (vld_p1_q) begin
      if (clr_p1_q) begin
        acc_p2_d = prod_ext;
        ovf_p2_d = 1'b0;
        cnt_p2_d = CNT_W'(1);
      end else begin
        acc_p2_d = add_res[ACC_W-1:0];
        ovf_p2_d = ovf_p2_q | add_res[ACC_W];
        if (cnt_p2_q != '1) cnt_p2_d = cnt_p2_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p2_q <= '0;
      ovf_p2_q <= 1'b0;
      vld_p2_q <= 1'b0;
      cnt_p2_q <= '0;
    end else begin
      acc_p2_q <= acc_p2_d;
      ovf_p2_q <= ovf_p2_d;
      vld_p2_q <= vld_p2_d;
      cnt_p2_q <= cnt_p2_d;
    end
  end

  assign accumulator = acc_p2_q;
  assign acc_valid   = vld_p2_q;
  assign overflow    = ovf_p2_q;
  assign mac_count   = cnt_p2_q;

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Bench for mac_acc_pipe: six configurations share one stimulus stream and are
// compared every cycle against a range-based arithmetic model, plus literal spot checks.
module tb_mac_acc_pipe;

  localparam int ACCW [6] = '{40, 32, 32, 40, 32, 32};
  localparam int SGNP [6] = '{0, 0, 0, 1, 1, 1};
  localparam int SATP [6] = '{1, 1, 0, 1, 1, 0};
  localparam int CW   [6] = '{16, 16, 4, 16, 16, 16};

  logic        clk = 1'b0;
  logic        reset, in_valid, clear;
  logic [15:0] A, B;

  logic [39:0] acc0, acc3;
  logic [31:0] acc1, acc2, acc4, acc5;
  logic [15:0] cnt0, cnt1, cnt3, cnt4, cnt5;
  logic [3:0]  cnt2;
  logic [5:0]  av, ov;

  logic [63:0] act_acc [6];
  logic [15:0] act_cnt [6];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_acc_pipe #(.N(16), .ACC_W(40), .SIGNED(0), .SAT(1), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .clear(clear), .A(A), .B(B),
    .accumulator(acc0), .acc_valid(av[0]), .overflow(ov[0]), .mac_count(cnt0));
  mac_acc_pipe #(.N(16), .ACC_W(32), .SIGNED(0), .SAT(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .clear(clear), .A(A), .B(B),
    .accumulator(acc1), .acc_valid(av[1]), .overflow(ov[1]), .mac_count(cnt1));
  mac_acc_pipe #(.N(16), .ACC_W(32), .SIGNED(0), .SAT(0), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .clear(clear), .A(A), .B(B),
    .accumulator(acc2), .acc_valid(av[2]), .overflow(ov[2]), .mac_count(cnt2));
  mac_acc_pipe #(.N(16), .ACC_W(40), .SIGNED(1), .SAT(1), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .clear(clear), .A(A), .B(B),
    .accumulator(acc3), .acc_valid(av[3]), .overflow(ov[3]), .mac_count(cnt3));
  mac_acc_pipe #(.N(16), .ACC_W(32), .SIGNED(1), .SAT(1), .CNT_W(16)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .clear(clear), .A(A), .B(B),
    .accumulator(acc4), .acc_valid(av[4]), .overflow(ov[4]), .mac_count(cnt4));
  mac_acc_pipe #(.N(16), .ACC_W(32), .SIGNED(1), .SAT(0), .CNT_W(16)) u5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .clear(clear), .A(A), .B(B),
    .accumulator(acc5), .acc_valid(av[5]), .overflow(ov[5]), .mac_count(cnt5));

  assign act_acc[0] = 64'(acc0);
  assign act_acc[1] = 64'(acc1);
  assign act_acc[2] = 64'(acc2);
  assign act_acc[3] = 64'(acc3);
  assign act_acc[4] = 64'(acc4);
  assign act_acc[5] = 64'(acc5);
  assign act_cnt[0] = cnt0;
  assign act_cnt[1] = cnt1;
  assign act_cnt[2] = 16'(cnt2);
  assign act_cnt[3] = cnt3;
  assign act_cnt[4] = cnt4;
  assign act_cnt[5] = cnt5;

  // Model state: the true mathematical sum (signed or unsigned) per configuration.
  longint      m_acc [6];
  bit          m_ovf [6];
  int          m_cnt [6];
  bit          m_vld;
  bit          armed = 1'b0;
  bit          pend_v, pend_c;
  logic [15:0] pend_a, pend_b;

  task automatic apply(input int k, input bit c, input logic [15:0] a, input logic [15:0] b);
    longint p, v, hi, lo, span;
    span = longint'(1) << ACCW[k];
    if (SGNP[k] != 0) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      hi = span / 2 - 1;
      lo = -(span / 2);
    end else begin
      p  = longint'(a) * longint'(b);
      hi = span - 1;
      lo = 0;
    end
    if (c) begin
      m_acc[k] = p;
      m_ovf[k] = 1'b0;
      m_cnt[k] = 1;
    end else begin
      v = m_acc[k] + p;
      if (v > hi || v < lo) begin
        m_ovf[k] = 1'b1;
        if (SATP[k] != 0) v = (v > hi) ? hi : lo;
        else              v = (v > hi) ? v - span : v + span;
      end
      m_acc[k] = v;
      if (m_cnt[k] < (1 << CW[k]) - 1) m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  function automatic logic [63:0] model_pat(input int k);
    return 64'(m_acc[k]) & ((64'(1) << ACCW[k]) - 64'(1));
  endfunction

  // An input accepted at one edge lands in the outputs at the next edge;
  // a reset edge wipes the sums and drops anything accepted but not yet summed.
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 6; k++) begin
        m_acc[k] = 0;
        m_ovf[k] = 1'b0;
        m_cnt[k] = 0;
      end
      m_vld  = 1'b0;
      pend_v = 1'b0;
      armed  = 1'b1;
    end else begin
      m_vld = pend_v;
      if (pend_v) for (int k = 0; k < 6; k++) apply(k, pend_c, pend_a, pend_b);
      pend_v = in_valid;
      pend_c = clear;
      pend_a = A;
      pend_b = B;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("d%0d.acc", k), act_acc[k], model_pat(k));
        chk($sformatf("d%0d.acc_valid", k), 64'(av[k]), 64'(m_vld));
        chk($sformatf("d%0d.overflow", k), 64'(ov[k]), 64'(m_ovf[k]));
        chk($sformatf("d%0d.mac_count", k), 64'(act_cnt[k]), 64'(m_cnt[k]));
      end
    end
  end

  task automatic lit(input int k, input string nm, input logic [63:0] acc, input logic v,
                     input logic o, input logic [15:0] cnt);
    chk({nm, ".acc"}, act_acc[k], acc);
    chk({nm, ".acc_valid"}, 64'(av[k]), 64'(v));
    chk({nm, ".overflow"}, 64'(ov[k]), 64'(o));
    chk({nm, ".mac_count"}, 64'(act_cnt[k]), 64'(cnt));
    chk({nm, ".model"}, model_pat(k), acc);
  endtask

  task automatic cyc(input logic v, input logic c, input logic [15:0] a, input logic [15:0] b,
                     input logic r = 1'b0);
    in_valid = v;
    clear    = c;
    A        = a;
    B        = b;
    reset    = r;
    @(negedge clk);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return 16'hFFFF - 16'($urandom_range(0, 255));
      2:       return 16'h8000 + 16'($urandom_range(0, 255));
      default: return 16'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; clear = 1'b0; A = '0; B = '0;
    repeat (2) cyc(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
    lit(0, "rst_hold", 64'd0, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 16'd0, 16'd0);
      lit(0, "idle", 64'd0, 1'b0, 1'b0, 16'd0);
    end

    cyc(1'b1, 1'b1, 16'd13, 16'd4);
    cyc(1'b1, 1'b0, 16'd7, 16'd3);
    lit(0, "b2b0", 64'd52, 1'b1, 1'b0, 16'd1);
    cyc(1'b1, 1'b0, 16'd3, 16'd6);
    lit(0, "b2b1", 64'd73, 1'b1, 1'b0, 16'd2);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    lit(0, "b2b2", 64'd91, 1'b1, 1'b0, 16'd3);

    cyc(1'b1, 1'b1, 16'd2, 16'd3);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    lit(0, "bub0", 64'd6, 1'b1, 1'b0, 16'd1);
    cyc(1'b1, 1'b0, 16'd2, 16'd8);
    lit(0, "bub1", 64'd6, 1'b0, 1'b0, 16'd1);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    lit(0, "bub2", 64'd22, 1'b1, 1'b0, 16'd2);

    cyc(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    cyc(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    lit(1, "sat0", 64'hFFFE_0001, 1'b1, 1'b0, 16'd1);
    lit(2, "wrap0", 64'hFFFE_0001, 1'b1, 1'b0, 16'd1);
    cyc(1'b1, 1'b1, 16'd2, 16'd8);
    lit(1, "sat1", 64'hFFFF_FFFF, 1'b1, 1'b1, 16'd2);
    lit(2, "wrap1", 64'hFFFC_0002, 1'b1, 1'b1, 16'd2);
    lit(0, "wide1", 64'h1_FFFC_0002, 1'b1, 1'b0, 16'd2);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    lit(1, "sat2", 64'd16, 1'b1, 1'b0, 16'd1);
    lit(2, "wrap2", 64'd16, 1'b1, 1'b0, 16'd1);

    cyc(1'b1, 1'b1, 16'hFFFD, 16'd5);
    cyc(1'b1, 1'b0, 16'd2, 16'd4);
    lit(3, "sgn0", 64'hFF_FFFF_FFF1, 1'b1, 1'b0, 16'd1);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    lit(3, "sgn1", 64'hFF_FFFF_FFF9, 1'b1, 1'b0, 16'd2);

    cyc(1'b1, 1'b1, 16'd13065, 16'd2);
    cyc(1'b1, 1'b0, 16'd14, 16'd2);
    lit(0, "pre_rst", 64'd26130, 1'b1, 1'b0, 16'd1);
    cyc(1'b1, 1'b0, 16'd9, 16'd9, 1'b1);
    lit(0, "mid_rst", 64'd0, 1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    lit(0, "after_rst0", 64'd0, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 16'd2, 16'd8);
    lit(0, "after_rst1", 64'd0, 1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    lit(0, "after_rst2", 64'd16, 1'b1, 1'b0, 16'd1);

    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), pick(), pick(),
          1'($urandom_range(0, 199) == 0));
    end
    repeat (3) cyc(1'b0, 1'b0, 16'd0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
